// File: rtl/exp_uart.sv
// exp_uart -- expansion-port serial card for the Z80 motherboard bus.
//
// An 8N1 UART answering at I/O ports &F8xx, BASE..BASE+3 (BASE[1:0] ignored):
//   0 DATA   R: received byte           W: transmit byte
//   1 STATUS b0 RXRDY, b1 TXE, b2 TXIDLE, b3 RXOVR, b4 FERR, b5 TXOVR, b7 irq
//            (read-only; reading it clears b3..b5)
//   2 CTRL   b0 RXIE, b1 TXIE, b7 LOOP
//   3 DIV    bit time = 16*(DIV+1) ce_16 ticks
// Optional feature macro: EXP_UART_IRQ_EN. When it is defined, the interrupt
// enables are stored and irq = (RXIE & RXRDY) | (TXIE & TXE). When it is not
// defined, irq is tied low and CTRL b0/b1 read back as 0.
//
// Ports:
//   clk, reset       system clock; asynchronous active-high reset
//   ce_16            16 MHz enable; all serial timing advances only on it
//   cpu_addr/dout    Z80 address and write data
//   iorq, rd, wr, m1 Z80 bus controls (active-high); iorq&m1 is never selected
//   cpu_din          read data, 8'hFF when not driving (the bus is ANDed)
//   irq              level interrupt request
//   rxd, txd         serial lines, idle high
module exp_uart #(
  parameter logic [7:0] BASE      = 8'hE0,
  parameter logic [7:0] DIV_RESET = 8'd103
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_16,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        iorq,
  input  logic        rd,
  input  logic        wr,
  input  logic        m1,
  output logic [7:0]  cpu_din,
  output logic        irq,
  input  logic        rxd,
  output logic        txd
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

  // ---------------- bus interface ----------------
  logic       sel, rd_act, wr_act, rd_act_q, wr_act_q, rd_stb, wr_stb;
  logic [1:0] reg_q;
  logic [7:0] wdata_q;

  assign sel    = iorq & ~m1 & (cpu_addr[15:8] == 8'hF8) & (cpu_addr[7:2] == BASE[7:2]);
  assign rd_act = sel & rd;
  assign wr_act = sel & wr;
  // Strobes fire as the access ends; register index and write data are held
  // from the access itself because the address may already have moved on.
  assign rd_stb = rd_act_q & ~rd_act;
  assign wr_stb = wr_act_q & ~wr_act;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_act_q <= 1'b0;
      wr_act_q <= 1'b0;
      reg_q    <= 2'd0;
      wdata_q  <= 8'd0;
    end else begin
      rd_act_q <= rd_act;
      wr_act_q <= wr_act;
      if (sel)    reg_q   <= cpu_addr[1:0];
      if (wr_act) wdata_q <= cpu_dout;
    end
  end

  logic wr_data, wr_ctrl, wr_div, rd_data, rd_status;
  assign wr_data   = wr_stb & (reg_q == 2'd0);
  assign wr_ctrl   = wr_stb & (reg_q == 2'd2);
  assign wr_div    = wr_stb & (reg_q == 2'd3);
  assign rd_data   = rd_stb & (reg_q == 2'd0);
  assign rd_status = rd_stb & (reg_q == 2'd1);

  // ---------------- registers and flags ----------------
  logic [7:0] hold, rx_buf, div_reg;
  logic       txe, rxrdy, rxovr, ferr, txovr, loop_en, rxie, txie;
  logic       tx_load, rx_stop_sample, rx_sync;
  logic [7:0] rx_sh;
  ser_state_t tx_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold    <= 8'd0;
      rx_buf  <= 8'd0;
      div_reg <= DIV_RESET;
      txe     <= 1'b1;
      rxrdy   <= 1'b0;
      rxovr   <= 1'b0;
      ferr    <= 1'b0;
      txovr   <= 1'b0;
      loop_en <= 1'b0;
    end else begin
      if (rd_status) begin
        rxovr <= 1'b0;
        ferr  <= 1'b0;
        txovr <= 1'b0;
      end
      if (rd_data) rxrdy <= 1'b0;
      if (wr_ctrl) loop_en <= wdata_q[7];
      if (wr_div)  div_reg <= wdata_q;
      if (tx_load) txe <= 1'b1;
      // A load in the same clock frees the holding register for the new byte.
      if (wr_data) begin
        if (txe | tx_load) begin
          hold <= wdata_q;
          txe  <= 1'b0;
        end else begin
          txovr <= 1'b1;
        end
      end
      if (rx_stop_sample) begin
        if (rxrdy & ~rd_data) begin
          rxovr <= 1'b1;
        end else begin
          rx_buf <= rx_sh;
          rxrdy  <= 1'b1;
        end
        if (~rx_sync) ferr <= 1'b1;
      end
    end
  end

`ifdef EXP_UART_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxie <= 1'b0;
      txie <= 1'b0;
    end else if (wr_ctrl) begin
      rxie <= wdata_q[0];
      txie <= wdata_q[1];
    end
  end
`else
  assign rxie = 1'b0;
  assign txie = 1'b0;
`endif

  assign irq = (rxie & rxrdy) | (txie & txe);

  // ---------------- read mux ----------------
  logic [7:0] status;
  assign status = {irq, 1'b0, txovr, ferr, rxovr, (tx_state == S_IDLE) & txe, txe, rxrdy};

  always_comb begin
    cpu_din = 8'hFF;
    if (rd_act) begin
      case (cpu_addr[1:0])
        2'd0:    cpu_din = rx_buf;
        2'd1:    cpu_din = status;
        2'd2:    cpu_din = {loop_en, 5'd0, txie, rxie};
        default: cpu_din = div_reg;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  logic [7:0] tx_pre, tx_div, tx_sh;
  logic [3:0] tx_tick;
  logic [2:0] tx_cnt;
  logic       txd_q, tx_tick_evt, tx_bit_end;

  assign tx_tick_evt = ce_16 & (tx_state != S_IDLE) & (tx_pre == tx_div);
  assign tx_bit_end  = tx_tick_evt & (tx_tick == 4'd15);
  // Loading straight out of STOP keeps back-to-back frames gapless.
  assign tx_load     = ~txe & ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_bit_end));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= S_IDLE;
      txd_q    <= 1'b1;
      tx_pre   <= 8'd0;
      tx_div   <= DIV_RESET;
      tx_tick  <= 4'd0;
      tx_cnt   <= 3'd0;
      tx_sh    <= 8'd0;
    end else begin
      if (ce_16 && tx_state != S_IDLE)
        tx_pre <= (tx_pre == tx_div) ? 8'd0 : tx_pre + 8'd1;
      if (tx_tick_evt) tx_tick <= tx_tick + 4'd1;
      // A new divisor is only picked up at a bit boundary.
      if (tx_bit_end) tx_div <= div_reg;
      if (tx_load) begin
        tx_state <= S_START;
        tx_sh    <= hold;
        txd_q    <= 1'b0;
        tx_pre   <= 8'd0;
        tx_tick  <= 4'd0;
        tx_div   <= div_reg;
      end else if (tx_bit_end) begin
        case (tx_state)
          S_START: begin
            tx_state <= S_DATA;
            txd_q    <= tx_sh[0];
            tx_cnt   <= 3'd0;
          end
          S_DATA: begin
            if (tx_cnt == 3'd7) begin
              tx_state <= S_STOP;
              txd_q    <= 1'b1;
            end else begin
              txd_q  <= tx_sh[1];
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx_cnt <= tx_cnt + 3'd1;
            end
          end
          default: tx_state <= S_IDLE;
        endcase
      end
    end
  end

  assign txd = loop_en ? 1'b1 : txd_q;

  // ---------------- receiver ----------------
  logic       rx_meta, rx_prev, rx_src, rx_tick_evt, rx_sample;
  logic [7:0] rx_pre, rx_div;
  logic [3:0] rx_tick;
  logic [2:0] rx_cnt;
  ser_state_t rx_state;

  assign rx_src      = loop_en ? txd_q : rxd;
  assign rx_tick_evt = ce_16 & (rx_state != S_IDLE) & (rx_pre == rx_div);
  // START samples half a bit after the edge; later states sample one bit on.
  assign rx_sample   = rx_tick_evt & (rx_tick == ((rx_state == S_START) ? 4'd7 : 4'd15));
  assign rx_stop_sample = rx_sample & (rx_state == S_STOP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_pre   <= 8'd0;
      rx_div   <= DIV_RESET;
      rx_tick  <= 4'd0;
      rx_cnt   <= 3'd0;
      rx_sh    <= 8'd0;
    end else begin
      rx_meta <= rx_src;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (ce_16 && rx_state != S_IDLE)
        rx_pre <= (rx_pre == rx_div) ? 8'd0 : rx_pre + 8'd1;
      if (rx_tick_evt) rx_tick <= rx_sample ? 4'd0 : rx_tick + 4'd1;
      case (rx_state)
        S_IDLE: if (rx_prev & ~rx_sync) begin
          rx_state <= S_START;
          rx_pre   <= 8'd0;
          rx_tick  <= 4'd0;
          rx_div   <= div_reg;
        end
        S_START: if (rx_sample) begin
          rx_state <= rx_sync ? S_IDLE : S_DATA;
          rx_cnt   <= 3'd0;
        end
        S_DATA: if (rx_sample) begin
          rx_sh <= {rx_sync, rx_sh[7:1]};
          if (rx_cnt == 3'd7) rx_state <= S_STOP;
          else                rx_cnt   <= rx_cnt + 3'd1;
        end
        default: if (rx_sample) rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_uart.sv
`timescale 1ns/1ps
module tb_exp_uart;

  localparam int BIT_CLKS = 128;   // DIV=3: 64 ce_16 per bit, ce_16 every other clk
  localparam time BIT_NS  = 1280;

  logic        clk = 1'b0, reset = 1'b1, ce_16 = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        iorq = 1'b0, rd = 1'b0, wr = 1'b0, m1 = 1'b0, rxd = 1'b1;
  logic [7:0]  cpu_din;
  logic        irq, txd;

  int  checks = 0, failures = 0;
  time t_fall = 0;
  bit  fell = 1'b0;

  exp_uart dut (
    .clk(clk), .reset(reset), .ce_16(ce_16), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .iorq(iorq), .rd(rd), .wr(wr), .m1(m1), .cpu_din(cpu_din), .irq(irq),
    .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;
  always @(negedge clk) ce_16 = ~ce_16;
  always @(negedge txd) begin
    t_fall = $time;
    fell   = 1'b1;
  end

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_dout = d; iorq = 1'b1; wr = 1'b1;
    repeat (3) @(negedge clk);
    iorq = 1'b0; wr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic io_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; iorq = 1'b1; rd = 1'b1;
    repeat (2) @(negedge clk);
    d = cpu_din;
    iorq = 1'b0; rd = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic wait_fall(output time t0);
    int n;
    n = 0;
    while (!fell && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!fell) begin
      failures++;
      $display("FAIL tx_start_edge: txd never fell within %0d clks", n);
    end
    t0 = t_fall;
  endtask

  task automatic wait_until(input time t);
    while ($time < t) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (3) @(negedge clk);
    checks++; if (txd !== 1'b1)      begin failures++; $display("FAIL reset_txd: got %b want 1", txd); end
    checks++; if (irq !== 1'b0)      begin failures++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++; if (cpu_din !== 8'hFF) begin failures++; $display("FAIL reset_din: got %h want ff", cpu_din); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    io_read(16'hF8E1, d);
    checks++; if (d !== 8'h06) begin failures++; $display("FAIL reset_status: got %h want 06", d); end
    io_read(16'hF8E3, d);
    checks++; if (d !== 8'd103) begin failures++; $display("FAIL reset_div: got %0d want 103", d); end
    io_read(16'hF8E4, d);
    checks++; if (d !== 8'hFF) begin failures++; $display("FAIL unselected_port: got %h want ff", d); end
    io_read(16'hF9E1, d);
    checks++; if (d !== 8'hFF) begin failures++; $display("FAIL wrong_high_byte: got %h want ff", d); end
    @(negedge clk);
    cpu_addr = 16'hF8E1; iorq = 1'b1; m1 = 1'b1; rd = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (cpu_din !== 8'hFF) begin failures++; $display("FAIL int_ack: got %h want ff", cpu_din); end
    iorq = 1'b0; m1 = 1'b0; rd = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_div();
    logic [7:0] d;
    io_write(16'hF8E3, 8'd3);
    io_read(16'hF8E3, d);
    checks++; if (d !== 8'd3) begin failures++; $display("FAIL div_write: got %0d want 3", d); end
  endtask

  task automatic test_tx();
    logic [9:0] expv;
    logic [7:0] d;
    time t0;
    expv = 10'b11_0100_1010;   // stop, &A5 MSB..LSB, start
    fell = 1'b0;
    io_write(16'hF8E0, 8'hA5);
    wait_fall(t0);
    for (int k = 0; k < 10; k++) begin
      wait_until(t0 + k * BIT_NS + BIT_NS / 2);
      checks++;
      if (txd !== expv[k]) begin
        failures++; $display("FAIL tx_bit%0d: got %b want %b", k, txd, expv[k]);
      end
    end
    wait_until(t0 + 10 * BIT_NS + 100);
    io_read(16'hF8E1, d);
    checks++; if (d !== 8'h06) begin failures++; $display("FAIL tx_idle_status: got %h want 06", d); end
  endtask

  task automatic test_rx();
    logic [7:0] d;
    send_rx(8'h3C, 1'b1);
    io_read(16'hF8E1, d);
    checks++; if (d !== 8'h07) begin failures++; $display("FAIL rx_rdy: got %h want 07", d); end
    io_read(16'hF8E0, d);
    checks++; if (d !== 8'h3C) begin failures++; $display("FAIL rx_data: got %h want 3c", d); end
    io_read(16'hF8E1, d);
    checks++; if (d !== 8'h06) begin failures++; $display("FAIL rx_rdy_clear: got %h want 06", d); end
  endtask

  task automatic test_rx_overrun_ferr();
    logic [7:0] d;
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    io_read(16'hF8E1, d);
    checks++; if (d !== 8'h0F) begin failures++; $display("FAIL rx_overrun: got %h want 0f", d); end
    io_read(16'hF8E0, d);
    checks++; if (d !== 8'h11) begin failures++; $display("FAIL rx_keep_old: got %h want 11", d); end
    io_read(16'hF8E1, d);
    checks++; if (d !== 8'h06) begin failures++; $display("FAIL rxovr_clear: got %h want 06", d); end
    send_rx(8'h55, 1'b0);
    io_read(16'hF8E1, d);
    checks++; if (d !== 8'h17) begin failures++; $display("FAIL ferr: got %h want 17", d); end
    io_read(16'hF8E0, d);
    checks++; if (d !== 8'h55) begin failures++; $display("FAIL ferr_data: got %h want 55", d); end
    io_read(16'hF8E1, d);
    checks++; if (d !== 8'h06) begin failures++; $display("FAIL ferr_clear: got %h want 06", d); end
  endtask

  task automatic test_back_to_back();
    logic [20:0] expv;
    logic [7:0]  d;
    time t0;
    // idle, stop, &00, start, stop, &FF, start (bit 0 first)
    expv = {1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0};
    fell = 1'b0;
    io_write(16'hF8E0, 8'hFF);
    wait_fall(t0);
    io_write(16'hF8E0, 8'h00);
    io_write(16'hF8E0, 8'h33);
    io_read(16'hF8E1, d);
    checks++; if (d !== 8'h20) begin failures++; $display("FAIL txovr: got %h want 20", d); end
    io_read(16'hF8E1, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL txovr_clear: got %h want 00", d); end
    for (int k = 0; k < 21; k++) begin
      wait_until(t0 + k * BIT_NS + BIT_NS / 2);
      checks++;
      if (txd !== expv[k]) begin
        failures++; $display("FAIL b2b_bit%0d: got %b want %b", k, txd, expv[k]);
      end
    end
    io_read(16'hF8E1, d);
    checks++; if (d !== 8'h06) begin failures++; $display("FAIL b2b_idle: got %h want 06", d); end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    rxd = 1'b0;
    repeat (29) @(negedge clk);   // ~290 ns, well short of half a bit
    rxd = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    io_read(16'hF8E1, d);
    checks++; if (d !== 8'h06) begin failures++; $display("FAIL glitch: got %h want 06", d); end
  endtask

  task automatic test_ctrl_loop();
    logic [7:0] d;
    int bad;
    io_write(16'hF8E2, 8'hFF);
    io_read(16'hF8E2, d);
`ifdef EXP_UART_IRQ_EN
    checks++; if (d !== 8'h83) begin failures++; $display("FAIL ctrl_rb: got %h want 83", d); end
`else
    checks++; if (d !== 8'h80) begin failures++; $display("FAIL ctrl_rb: got %h want 80", d); end
`endif
    io_write(16'hF8E2, 8'h80);
    io_write(16'hF8E0, 8'h5A);
    bad = 0;
    for (int i = 0; i < 11 * BIT_CLKS; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL loop_txd_held: %0d low samples want 0", bad); end
    io_read(16'hF8E1, d);
    checks++; if (d !== 8'h07) begin failures++; $display("FAIL loop_status: got %h want 07", d); end
    io_read(16'hF8E0, d);
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL loop_data: got %h want 5a", d); end
    io_write(16'hF8E2, 8'h00);
  endtask

  task automatic test_irq();
    logic [7:0] d;
`ifdef EXP_UART_IRQ_EN
    io_write(16'hF8E2, 8'h01);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_empty: got %b want 0", irq); end
    send_rx(8'h99, 1'b1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rx: got %b want 1", irq); end
    io_read(16'hF8E1, d);
    checks++; if (d !== 8'h87) begin failures++; $display("FAIL irq_status: got %h want 87", d); end
    io_read(16'hF8E0, d);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear: got %b want 0", irq); end
    io_write(16'hF8E2, 8'h02);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_tx: got %b want 1", irq); end
    io_write(16'hF8E2, 8'h00);
`else
    io_write(16'hF8E2, 8'h03);
    send_rx(8'h99, 1'b1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_off: got %b want 0", irq); end
    io_read(16'hF8E1, d);
    checks++; if (d !== 8'h07) begin failures++; $display("FAIL irq_off_status: got %h want 07", d); end
    io_read(16'hF8E0, d);
    io_write(16'hF8E2, 8'h00);
`endif
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    time t0;
    fell = 1'b0;
    io_write(16'hF8E0, 8'h00);
    wait_fall(t0);
    wait_until(t0 + 3 * BIT_NS + BIT_NS / 2);
    checks++; if (txd !== 1'b0) begin failures++; $display("FAIL midframe_low: got %b want 0", txd); end
    #2 reset = 1'b1;
    #1;
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL async_reset_txd: got %b want 1", txd); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    io_read(16'hF8E1, d);
    checks++; if (d !== 8'h06) begin failures++; $display("FAIL post_reset_status: got %h want 06", d); end
    io_read(16'hF8E3, d);
    checks++; if (d !== 8'd103) begin failures++; $display("FAIL post_reset_div: got %0d want 103", d); end
  endtask

  initial begin
    test_reset();
    test_div();
    test_tx();
    test_rx();
    test_rx_overrun_ferr();
    test_back_to_back();
    test_glitch();
    test_ctrl_loop();
    test_irq();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
